// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receiver.
package uart_pkg;

  // Default link setup: 50 MHz system clock, 115200 baud, 8 data bits.
  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int DEFAULT_DATA_BITS    = 8;

  // Parity modes.
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Transmitter frame states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_t;

  // Parity bit for a data word zero-extended to 8 bits; the padding does not
  // change the XOR. Even mode returns the XOR of the data, odd mode its inverse.
  function automatic logic calc_parity(input logic [7:0] d, input int mode);
    return (mode == PARITY_ODD) ? ~(^d) : ^d;
  endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Valid/ready byte handshake between a producer and the UART transmitter.
interface uart_transmitter_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS
) ();

  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 rdy;

  modport master (output data, output valid, input rdy);
  modport slave  (input data, input valid, output rdy);

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each
// bit. Shared between the UART transmitter and receiver.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_done
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Restart pins the count to zero so the next bit starts with a full period.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_done = (cnt == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: serialises bytes from the command/status logic onto uart_tx
// with START, LSB-first data, optional parity and one or two STOP bits.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic                clk,
  input  logic                reset,
  uart_transmitter_if.slave   bus,
  output logic                busy,
  output logic                uart_tx
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  uart_tx_state_t       state, state_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic [2:0]           bit_idx, bit_idx_next;
  logic                 stop_idx, stop_idx_next;
  logic                 par_bit, par_bit_next;
  logic                 tx_next;
  logic                 bit_done;
  logic                 rdy;
  logic                 accept;
  logic                 restart;
  logic [7:0]           data_ext;

  uart_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .restart  (restart),
    .bit_done (bit_done)
  );

  // Ready in IDLE or on the very last cycle of the final stop bit, which lets
  // a new frame follow with no idle gap.
  always_comb begin
    rdy      = (state == ST_IDLE) ||
               ((state == ST_STOP) && bit_done && (stop_idx == LAST_STOP));
    accept   = bus.valid && rdy;
    restart  = (state == ST_IDLE) || accept;
    data_ext = '0;
    data_ext[DATA_BITS-1:0] = bus.data;
  end

  assign bus.rdy = rdy;
  assign busy    = (state != ST_IDLE);

  // Next-state and next-line logic; an accept overrides the frame sequencing.
  always_comb begin
    state_next    = state;
    shift_next    = shift;
    bit_idx_next  = bit_idx;
    stop_idx_next = stop_idx;
    par_bit_next  = par_bit;
    tx_next       = 1'b1;

    unique case (state)
      ST_IDLE: begin
      end
      ST_START: begin
        if (bit_done) begin
          state_next   = ST_DATA;
          bit_idx_next = '0;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          shift_next = shift >> 1;
          if (bit_idx == LAST_BIT) begin
            state_next    = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            stop_idx_next = 1'b0;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          state_next    = ST_STOP;
          stop_idx_next = 1'b0;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          if (stop_idx == LAST_STOP) begin
            state_next = ST_IDLE;
          end else begin
            stop_idx_next = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (accept) begin
      state_next    = ST_START;
      shift_next    = bus.data;
      par_bit_next  = calc_parity(data_ext, PARITY);
      bit_idx_next  = '0;
      stop_idx_next = 1'b0;
    end

    unique case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shift_next[0];
      ST_PARITY: tx_next = par_bit_next;
      default:   tx_next = 1'b1;
    endcase
  end

  // State and registered serial line; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      shift    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      par_bit  <= 1'b0;
      uart_tx  <= 1'b1;
    end else begin
      state    <= state_next;
      shift    <= shift_next;
      bit_idx  <= bit_idx_next;
      stop_idx <= stop_idx_next;
      par_bit  <= par_bit_next;
      uart_tx  <= tx_next;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: four configurations (8N1, 8E1,
// 8O1, 7N2) run side by side against a frame-queue reference model.
module tb_uart_transmitter;
  import uart_pkg::*;

  localparam int N = 4;
  localparam int CPB   [N] = '{4, 4, 4, 4};
  localparam int DBITS [N] = '{8, 8, 8, 7};
  localparam int PMODE [N] = '{PARITY_NONE, PARITY_EVEN, PARITY_ODD, PARITY_NONE};
  localparam int SBITS [N] = '{1, 1, 1, 2};

  logic       clk;
  logic       reset;
  logic       tb_valid;
  logic [7:0] tb_data;

  logic busy_a, busy_b, busy_c, busy_d;
  logic tx_a, tx_b, tx_c, tx_d;
  logic obs_tx [N];
  logic obs_rdy [N];
  logic obs_busy [N];

  int compared;
  int mismatched;

  logic [127:0] pend [N];
  int           plen [N];

  uart_transmitter_if #(.DATA_BITS(8)) if_a ();
  uart_transmitter_if #(.DATA_BITS(8)) if_b ();
  uart_transmitter_if #(.DATA_BITS(8)) if_c ();
  uart_transmitter_if #(.DATA_BITS(7)) if_d ();

  assign if_a.data  = tb_data;
  assign if_b.data  = tb_data;
  assign if_c.data  = tb_data;
  assign if_d.data  = tb_data[6:0];
  assign if_a.valid = tb_valid;
  assign if_b.valid = tb_valid;
  assign if_c.valid = tb_valid;
  assign if_d.valid = tb_valid;

  uart_transmitter #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(PARITY_NONE), .STOP_BITS(1))
    dut_a (.clk(clk), .reset(reset), .bus(if_a), .busy(busy_a), .uart_tx(tx_a));
  uart_transmitter #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(PARITY_EVEN), .STOP_BITS(1))
    dut_b (.clk(clk), .reset(reset), .bus(if_b), .busy(busy_b), .uart_tx(tx_b));
  uart_transmitter #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(PARITY_ODD), .STOP_BITS(1))
    dut_c (.clk(clk), .reset(reset), .bus(if_c), .busy(busy_c), .uart_tx(tx_c));
  uart_transmitter #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(PARITY_NONE), .STOP_BITS(2))
    dut_d (.clk(clk), .reset(reset), .bus(if_d), .busy(busy_d), .uart_tx(tx_d));

  assign obs_tx[0] = tx_a;  assign obs_rdy[0] = if_a.rdy;  assign obs_busy[0] = busy_a;
  assign obs_tx[1] = tx_b;  assign obs_rdy[1] = if_b.rdy;  assign obs_busy[1] = busy_b;
  assign obs_tx[2] = tx_c;  assign obs_rdy[2] = if_c.rdy;  assign obs_busy[2] = busy_c;
  assign obs_tx[3] = tx_d;  assign obs_rdy[3] = if_d.rdy;  assign obs_busy[3] = busy_d;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line level for every cycle of one frame: START, data LSB first, optional
  // parity, stop bits; each bit repeated for a full bit period.
  function automatic logic [127:0] build_frame(input logic [7:0] d, input int k,
                                               output int flen);
    logic [127:0] f;
    logic         bits [$];
    int           ones;
    logic [7:0]   m;
    f    = '0;
    flen = 0;
    m    = 8'((9'd1 << DBITS[k]) - 9'd1);
    ones = $countones(d & m);
    bits.push_back(1'b0);
    for (int i = 0; i < DBITS[k]; i++) bits.push_back(d[i]);
    if (PMODE[k] == PARITY_EVEN) bits.push_back(1'((ones % 2) == 1));
    if (PMODE[k] == PARITY_ODD)  bits.push_back(1'((ones % 2) == 0));
    for (int i = 0; i < SBITS[k]; i++) bits.push_back(1'b1);
    foreach (bits[j]) begin
      for (int c = 0; c < CPB[k]; c++) begin
        f[flen] = bits[j];
        flen++;
      end
    end
    return f;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One clock cycle: drive inputs, advance the reference queues at the edge,
  // then compare every DUT a little after the edge.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
    logic [127:0] f;
    int           fl;
    logic         acc;
    tb_valid = v;
    tb_data  = d;
    reset    = r;
    @(posedge clk);
    for (int k = 0; k < N; k++) begin
      if (r) begin
        pend[k] = '0;
        plen[k] = 0;
      end else begin
        acc = v && (plen[k] <= 1);
        if (plen[k] > 0) begin
          pend[k] = pend[k] >> 1;
          plen[k] = plen[k] - 1;
        end
        if (acc) begin
          f = build_frame(d, k, fl);
          pend[k] = pend[k] | (f << plen[k]);
          plen[k] = plen[k] + fl;
        end
      end
    end
    #1;
    for (int k = 0; k < N; k++) begin
      checkOutput($sformatf("dut%0d.uart_tx", k), 32'(obs_tx[k]),
                  32'((plen[k] == 0) ? 1'b1 : pend[k][0]));
      checkOutput($sformatf("dut%0d.busy", k), 32'(obs_busy[k]), 32'(plen[k] != 0));
      checkOutput($sformatf("dut%0d.rdy", k), 32'(obs_rdy[k]), 32'(plen[k] <= 1));
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    tb_valid   = 1'b0;
    tb_data    = 8'h00;
    reset      = 1'b1;
    for (int k = 0; k < N; k++) begin
      pend[k] = '0;
      plen[k] = 0;
    end

    repeat (2) applyStimulus(1'b0, 8'h00, 1'b1);
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b0);

    // Single byte 0xA5, then drain.
    applyStimulus(1'b1, 8'hA5, 1'b0);
    repeat (50) applyStimulus(1'b0, 8'h00, 1'b0);

    // 0x07 exercises both parity polarities.
    applyStimulus(1'b1, 8'h07, 1'b0);
    repeat (50) applyStimulus(1'b0, 8'h00, 1'b0);

    // Back-to-back: valid held, 0x55 then 0xAA.
    applyStimulus(1'b1, 8'h55, 1'b0);
    repeat (100) applyStimulus(1'b1, 8'hAA, 1'b0);
    repeat (50) applyStimulus(1'b0, 8'h00, 1'b0);

    // Valid pulse with 0xFF mid-frame must be ignored.
    applyStimulus(1'b1, 8'hA5, 1'b0);
    repeat (10) applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    repeat (50) applyStimulus(1'b0, 8'h00, 1'b0);

    // Reset during data bit 3, then 0x3C sends cleanly.
    applyStimulus(1'b1, 8'h3C, 1'b0);
    repeat (18) applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h3C, 1'b0);
    repeat (50) applyStimulus(1'b0, 8'h00, 1'b0);

    // 7-bit, two stop bits: 0x41.
    applyStimulus(1'b1, 8'h41, 1'b0);
    repeat (50) applyStimulus(1'b0, 8'h00, 1'b0);

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 8'($urandom),
                    1'($urandom_range(0, 299) == 0));
    end
    repeat (60) applyStimulus(1'b0, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
UART transmitter, the TX counterpart of the plotter's existing `uart_rx` path. It serialises bytes from the command/status logic onto `uart_tx`, e.g. acknowledgements and "ready for next command" tokens back to the host. It sits beside the receiver inside the plotter top level and uses the same frame format.

Parameters:
CLKS_PER_BIT, 434, system clock cycles per UART bit (50 MHz / 115200); must be >= 2.
DATA_BITS, 8, data bits per frame, 5..8.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
data  input  DATA_BITS  byte to send; sampled only on the accept cycle.
valid  input  1  producer has a byte on `data`.
rdy  output  1  transmitter can accept a byte this cycle.
busy  output  1  a frame is in progress (START through final STOP).
uart_tx  output  1  serial line; idles high.

Behaviour:
- One clock (`clk`); reset is synchronous and active-high (`reset`).
- Reset values: `uart_tx`=1, `rdy`=1, `busy`=0, state=IDLE, all counters 0, shift register 0.
- States:
  - IDLE: `uart_tx`=1.
  - START: `uart_tx`=0.
  - DATA: `uart_tx`=shift[0], LSB first.
  - PARITY: present only if PARITY != 0.
  - STOP: `uart_tx`=1, lasts STOP_BITS bit periods.
- Accept occurs on a cycle with `valid`&&`rdy`.
  - `data` is latched into the shift register and the parity bit is computed from the latched value.
  - The next cycle is the first cycle of START.
  - `data` changes after accept have no effect on the frame.
- Each bit is held exactly CLKS_PER_BIT cycles; a baud counter runs 0..CLKS_PER_BIT-1 and restarts at every bit boundary.
- DATA advances bit index 0..DATA_BITS-1, shifting right at each bit boundary; after the last data bit it goes to PARITY, or to STOP if PARITY=0.
- Parity bit:
  - even mode: XOR of the data bits.
  - odd mode: inverted XOR of the data bits.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles, counted from the first START cycle to the last STOP cycle inclusive.
- `rdy` is 1 in IDLE and in the final cycle of the final stop bit, 0 otherwise.
  - Accept in that final stop cycle goes directly to START with no idle gap (back-to-back frames).
  - Without accept in that cycle, the next state is IDLE.
- `busy`=1 from the first START cycle through the last STOP cycle. It is 0 in IDLE, including the IDLE cycle on which an accept happens.
- `uart_tx` is registered and glitch-free; it changes only on bit boundaries.
- Reset mid-frame aborts the frame: next cycle `uart_tx`=1, `rdy`=1, state IDLE. No partial frame resumes afterwards.
- `valid` asserted while `rdy`=0 is ignored, not queued; the producer must hold `valid` until accepted.

Decomposition:
- Shared package `uart_pkg`:
  - state enum `uart_tx_state_t` (IDLE, START, DATA, PARITY, STOP).
  - parity mode constants PARITY_NONE / PARITY_ODD / PARITY_EVEN.
  - default CLKS_PER_BIT and DATA_BITS constants, shared with the receiver.
- Sub-module `uart_baud_counter`:
  - parameter CLKS_PER_BIT; inputs `clk`, `reset`, `restart`.
  - output `bit_done`, a pulse on the last cycle of each bit period.
  - reusable by the receiver.

Test Plan:
- Reset, CLKS_PER_BIT=4, 8N1; send 0xA5 -> after accept, `uart_tx` sequence per bit is 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; `busy` high exactly 40 cycles; `rdy` high in cycle 40 only.
- Even parity with 0x07, then odd parity with 0x07 -> parity bit 1 (even), 0 (odd); frame is 44 cycles at CLKS_PER_BIT=4.
- `valid` held high with 0x55 then 0xAA -> second START begins the cycle right after the first frame's last stop cycle; no idle cycle between frames; decoded bytes 0x55, 0xAA.
- Pulse `valid` while `busy` with 0xFF mid-frame -> ignored: the current frame is unchanged and no second frame follows.
- Assert `reset` during data bit 3 -> next cycle `uart_tx`=1, `rdy`=1, `busy`=0; a new byte 0x3C then sends correctly.
- STOP_BITS=2, DATA_BITS=7, 0x41 -> stop high for 8 cycles; total frame 40 cycles; a loopback through the receiver returns 0x41.
